// File: rtl/dbg_cmd_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dbg_cmd_engine                                              |
// | Purpose  : Debug-command engine between the debug UART byte streams    |
// |            and the system bus master port. Decodes host opcodes, runs  |
// |            burst reads/writes with address auto-increment, drives the  |
// |            core reset hold, and closes every command with a CRC-8.     |
// | Ports    : clk/asyncrst        clock, async active-high reset          |
// |            rx_byte/rx_valid    UART RX byte strobe (no backpressure)   |
// |            tx_byte/tx_valid/tx_ready  UART TX handshake                |
// |            bus_addr/bus_wdata/bus_ren/bus_wen/bus_busy/bus_rdata       |
// |                                bus master port                         |
// |            core_rst            core reset hold                         |
// |            err                 sticky {timeout, overrun, bad_opcode}   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module dbg_cmd_engine #(
   parameter int   ADDR_W        = 32,
   parameter int   DATA_W        = 32,
   parameter int   CNT_W         = 8,
   parameter int   TIMEOUT_CYC   = 65535,
   parameter logic CORE_RST_INIT = 1'b0
) (
   input  logic              clk,
   input  logic              asyncrst,
   input  logic [7:0]        rx_byte,
   input  logic              rx_valid,
   output logic [7:0]        tx_byte,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_ren,
   output logic              bus_wen,
   input  logic              bus_busy,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              core_rst,
   output logic [2:0]        err
);

   localparam logic [7:0] c_NB = 8'(DATA_W / 8);
   localparam logic [7:0] c_AB = 8'(ADDR_W / 8);
   localparam int         c_TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

   localparam logic [7:0] c_OP_SET_COUNT = 8'h82;
   localparam logic [7:0] c_OP_SET_ADDR  = 8'h83;
   localparam logic [7:0] c_OP_READ      = 8'h84;
   localparam logic [7:0] c_OP_WRITE     = 8'h85;
   localparam logic [7:0] c_OP_ALIVE     = 8'h86;
   localparam logic [7:0] c_OP_CORE_RST  = 8'h87;
   localparam logic [7:0] c_OP_CORE_NORM = 8'h88;

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_RX_ARG  = 3'd1;
   localparam logic [2:0] c_ST_BUS     = 3'd2;
   localparam logic [2:0] c_ST_TX_DATA = 3'd3;
   localparam logic [2:0] c_ST_TX_CRC  = 3'd4;

   logic [2:0]         r_state, w_state_nxt;
   logic [7:0]         r_op;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W-1:0]  r_abuf;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic [CNT_W-1:0]   r_count;
   logic [7:0]         r_bidx;
   logic [c_TMO_W-1:0] r_tmo;
   logic [7:0]         r_crc;
   logic               r_core_rst;
   logic [2:0]         r_err;

   logic [7:0]         w_arg_len;
   logic               w_arg_last;
   logic               w_tx_last;
   logic               w_op_ok;
   logic               w_bus_acc;
   logic               w_tx_acc;
   logic               w_timeout;
   logic               w_overrun;
   logic               w_bad_op;
   logic               w_err_clr;
   logic [ADDR_W-1:0]  w_abuf_sh;

   // MSB-first CRC-8, polynomial x^8+x^2+x+1
   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   always_comb begin
      w_arg_len = 8'd1;
      case (r_op)
         c_OP_SET_ADDR: w_arg_len = c_AB;
         c_OP_WRITE:    w_arg_len = c_NB;
         default:       w_arg_len = 8'd1;
      endcase
   end

   assign w_arg_last = (r_bidx == w_arg_len - 8'd1);
   assign w_tx_last  = (r_bidx == ((r_op == c_OP_ALIVE) ? 8'd1 : c_NB - 8'd1));
   assign w_op_ok    = (rx_byte >= c_OP_SET_COUNT) && (rx_byte <= c_OP_CORE_NORM);
   assign w_bus_acc  = (r_state == c_ST_BUS) && !bus_busy;
   assign w_tx_acc   = tx_valid && tx_ready;
   assign w_timeout  = (r_state == c_ST_RX_ARG) && !rx_valid && (r_tmo == c_TMO_LAST);
   assign w_overrun  = rx_valid && ((r_state == c_ST_BUS) || (r_state == c_ST_TX_DATA) ||
                                    (r_state == c_ST_TX_CRC));
   assign w_bad_op   = (r_state == c_ST_IDLE) && rx_valid && !w_op_ok;
   assign w_err_clr  = (r_state == c_ST_IDLE) && rx_valid && (rx_byte == c_OP_ALIVE);
   assign w_abuf_sh  = (r_abuf << 8) | ADDR_W'(rx_byte);

   // State register
   always_ff @(posedge clk or posedge asyncrst) begin
      if (asyncrst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (rx_valid) begin
               case (rx_byte)
                  c_OP_SET_COUNT, c_OP_SET_ADDR: w_state_nxt = c_ST_RX_ARG;
                  c_OP_WRITE:  w_state_nxt = (r_count != '0) ? c_ST_RX_ARG : c_ST_TX_CRC;
                  c_OP_READ:   w_state_nxt = (r_count != '0) ? c_ST_BUS : c_ST_TX_CRC;
                  c_OP_ALIVE:  w_state_nxt = c_ST_TX_DATA;
                  c_OP_CORE_RST, c_OP_CORE_NORM: w_state_nxt = c_ST_TX_CRC;
                  default:     w_state_nxt = c_ST_IDLE;
               endcase
            end
         end
         c_ST_RX_ARG: begin
            if (rx_valid) begin
               if (w_arg_last) begin
                  w_state_nxt = (r_op == c_OP_WRITE) ? c_ST_BUS : c_ST_TX_CRC;
               end
            end else if (w_timeout) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_BUS: begin
            if (w_bus_acc) begin
               if (r_op == c_OP_READ) begin
                  w_state_nxt = c_ST_TX_DATA;
               end else begin
                  w_state_nxt = (r_count == CNT_W'(1)) ? c_ST_TX_CRC : c_ST_RX_ARG;
               end
            end
         end
         c_ST_TX_DATA: begin
            if (w_tx_acc && w_tx_last) begin
               // r_count was already decremented on the bus accept
               if ((r_op == c_OP_READ) && (r_count != '0)) begin
                  w_state_nxt = c_ST_BUS;
               end else begin
                  w_state_nxt = c_ST_TX_CRC;
               end
            end
         end
         c_ST_TX_CRC: begin
            if (w_tx_acc) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Outputs decoded from state so an async reset drops them at once
   always_comb begin
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      bus_ren  = 1'b0;
      bus_wen  = 1'b0;
      case (r_state)
         c_ST_BUS: begin
            bus_ren = (r_op == c_OP_READ);
            bus_wen = (r_op == c_OP_WRITE);
         end
         c_ST_TX_DATA: begin
            tx_valid = 1'b1;
            if (r_op == c_OP_ALIVE) begin
               tx_byte = (r_bidx == 8'd0) ? 8'h00 : 8'hAE;
            end else begin
               tx_byte = r_rdata[DATA_W-1 -: 8];
            end
         end
         c_ST_TX_CRC: begin
            tx_valid = 1'b1;
            tx_byte  = r_crc;
         end
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or posedge asyncrst) begin
      if (asyncrst) begin
         r_op       <= 8'h00;
         r_addr     <= '0;
         r_abuf     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_count    <= '0;
         r_bidx     <= 8'd0;
         r_tmo      <= '0;
         r_crc      <= 8'h00;
         r_core_rst <= CORE_RST_INIT;
         r_err      <= 3'b000;
      end else begin
         // A same-cycle error event wins over the ALIVE clear
         r_err <= (w_err_clr ? 3'b000 : r_err) | {w_timeout, w_overrun, w_bad_op};
         case (r_state)
            c_ST_IDLE: begin
               if (rx_valid && w_op_ok) begin
                  r_op   <= rx_byte;
                  r_crc  <= crc8_upd(8'h00, rx_byte);
                  r_bidx <= 8'd0;
                  r_tmo  <= '0;
                  if (rx_byte == c_OP_CORE_RST) begin
                     r_core_rst <= 1'b1;
                  end
                  if (rx_byte == c_OP_CORE_NORM) begin
                     r_core_rst <= 1'b0;
                  end
               end
            end
            c_ST_RX_ARG: begin
               if (rx_valid) begin
                  r_crc  <= crc8_upd(r_crc, rx_byte);
                  r_tmo  <= '0;
                  r_bidx <= w_arg_last ? 8'd0 : r_bidx + 8'd1;
                  case (r_op)
                     c_OP_SET_COUNT: r_count <= rx_byte[CNT_W-1:0];
                     c_OP_SET_ADDR: begin
                        // Address only commits once complete, so a timeout leaves it intact
                        r_abuf <= w_abuf_sh;
                        if (w_arg_last) begin
                           r_addr <= w_abuf_sh;
                        end
                     end
                     default: r_wdata <= (r_wdata << 8) | DATA_W'(rx_byte);
                  endcase
               end else begin
                  r_tmo <= r_tmo + c_TMO_W'(1);
               end
            end
            c_ST_BUS: begin
               if (w_bus_acc) begin
                  r_addr  <= r_addr + ADDR_W'(DATA_W / 8);
                  r_count <= r_count - CNT_W'(1);
                  r_bidx  <= 8'd0;
                  r_tmo   <= '0;
                  if (r_op == c_OP_READ) begin
                     r_rdata <= bus_rdata;
                  end
               end
            end
            c_ST_TX_DATA: begin
               if (w_tx_acc) begin
                  r_crc   <= crc8_upd(r_crc, tx_byte);
                  r_bidx  <= r_bidx + 8'd1;
                  r_rdata <= r_rdata << 8;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign core_rst  = r_core_rst;
   assign err       = r_err;

endmodule
`default_nettype wire
